// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the non-forwarding 5-stage pipeline.
// Tracks destination registers in flight in EX/MEM/WB, stalls the ID
// instruction on RAW hazards, flushes on redirects, freezes on LSU busy,
// and keeps saturating stall/flush counters.
module hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int CNT_W     = 32,
    parameter bit WB_BYPASS = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_id_vld,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_rs1_used,
    input  logic              i_id_rs2_used,
    input  logic [REG_AW-1:0] i_id_rd,
    input  logic              i_id_rd_wren,
    input  logic              i_ex_pc_sel,
    input  logic              i_lsu_stall,
    output logic              o_pc_en,
    output logic              o_if_id_en,
    output logic              o_if_id_flush,
    output logic              o_id_ex_en,
    output logic              o_id_ex_flush,
    output logic              o_ex_mem_en,
    output logic              o_mem_wb_en,
    output logic              o_raw_stall,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    // Slot 0 = EX, 1 = MEM, 2 = WB. With a write-through register file the
    // WB slot can no longer cause a hazard, so only the first two are checked.
    localparam int N_SLOTS = 3;
    localparam int N_CHECK = WB_BYPASS ? 2 : 3;

    typedef enum logic [1:0] {
        MODE_RUN,
        MODE_RAW,
        MODE_REDIRECT,
        MODE_FREEZE
    } mode_e;

    logic              sb_wr_q [N_SLOTS];
    logic [REG_AW-1:0] sb_rd_q [N_SLOTS];
    logic              sb_wr_d [N_SLOTS];
    logic [REG_AW-1:0] sb_rd_d [N_SLOTS];
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [N_SLOTS-1:0] hit;
    logic              raw;
    mode_e             mode;

    // Per-slot RAW match; x0 and unused operands never match.
    generate
        for (genvar gi = 0; gi < N_SLOTS; gi++) begin : g_hit
            if (gi < N_CHECK) begin : g_chk
                assign hit[gi] = sb_wr_q[gi] && (sb_rd_q[gi] != '0) &&
                                 ((i_id_rs1_used && (i_id_rs1 == sb_rd_q[gi])) ||
                                  (i_id_rs2_used && (i_id_rs2 == sb_rd_q[gi])));
            end else begin : g_skip
                assign hit[gi] = 1'b0;
            end
        end
    endgenerate

    assign raw = i_id_vld && (|hit);

    // Mode priority decode, pipeline controls and scoreboard/counter next state.
    always_comb begin
        mode = MODE_RUN;
        if (i_lsu_stall) begin
            mode = MODE_FREEZE;
        end else if (i_ex_pc_sel) begin
            mode = MODE_REDIRECT;
        end else if (raw) begin
            mode = MODE_RAW;
        end

        o_pc_en       = 1'b1;
        o_if_id_en    = 1'b1;
        o_if_id_flush = 1'b0;
        o_id_ex_en    = 1'b1;
        o_id_ex_flush = 1'b0;
        o_ex_mem_en   = 1'b1;
        o_mem_wb_en   = 1'b1;
        o_raw_stall   = 1'b0;

        sb_wr_d[0] = i_id_vld && i_id_rd_wren;
        sb_rd_d[0] = i_id_rd;
        for (int i = 1; i < N_SLOTS; i++) begin
            sb_wr_d[i] = sb_wr_q[i-1];
            sb_rd_d[i] = sb_rd_q[i-1];
        end
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        case (mode)
            MODE_FREEZE: begin
                o_pc_en     = 1'b0;
                o_if_id_en  = 1'b0;
                o_id_ex_en  = 1'b0;
                o_ex_mem_en = 1'b0;
                o_mem_wb_en = 1'b0;
                for (int i = 0; i < N_SLOTS; i++) begin
                    sb_wr_d[i] = sb_wr_q[i];
                    sb_rd_d[i] = sb_rd_q[i];
                end
            end
            MODE_REDIRECT: begin
                o_if_id_flush = 1'b1;
                o_id_ex_flush = 1'b1;
                sb_wr_d[0]    = 1'b0;
                sb_rd_d[0]    = '0;
                flush_cnt_d   = (flush_cnt_q == {CNT_W{1'b1}}) ? flush_cnt_q
                                                               : flush_cnt_q + CNT_W'(1);
            end
            MODE_RAW: begin
                o_pc_en       = 1'b0;
                o_if_id_en    = 1'b0;
                o_id_ex_flush = 1'b1;
                o_raw_stall   = 1'b1;
                sb_wr_d[0]    = 1'b0;
                sb_rd_d[0]    = '0;
                stall_cnt_d   = (stall_cnt_q == {CNT_W{1'b1}}) ? stall_cnt_q
                                                               : stall_cnt_q + CNT_W'(1);
            end
            default: begin
            end
        endcase

        // While in reset the pipeline runs with both stage registers cleared.
        if (i_reset) begin
            o_pc_en       = 1'b1;
            o_if_id_en    = 1'b1;
            o_if_id_flush = 1'b1;
            o_id_ex_en    = 1'b1;
            o_id_ex_flush = 1'b1;
            o_ex_mem_en   = 1'b1;
            o_mem_wb_en   = 1'b1;
            o_raw_stall   = 1'b0;
        end
    end

    // Scoreboard and counter registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < N_SLOTS; i++) begin
                sb_wr_q[i] <= 1'b0;
                sb_rd_q[i] <= '0;
            end
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_SLOTS; i++) begin
                sb_wr_q[i] <= sb_wr_d[i];
                sb_rd_q[i] <= sb_rd_d[i];
            end
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the non-forwarding 5-stage core (IF, ID, EX, MEM, WB).
- Sits upstream of the ID/EX and IF/ID pipeline registers and drives their enable and flush controls, plus the PC enable.
- Keeps an internal scoreboard of destination registers in flight in EX/MEM/WB, detects RAW hazards for the instruction in ID, and inserts bubbles.
- Applies branch/jump redirect flushes and global LSU freezes, and keeps saturating performance counters.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, performance counter width.
- WB_BYPASS, 0: 0 = register file has no write-through, so the WB slot is checked; 1 = WB slot is excluded from hazard checks.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  synchronous reset, active-high.
- i_id_vld  in  1  ID stage holds a valid instruction.
- i_id_rs1  in  REG_AW  rs1 address of the ID instruction.
- i_id_rs2  in  REG_AW  rs2 address of the ID instruction.
- i_id_rs1_used  in  1  ID instruction reads rs1.
- i_id_rs2_used  in  1  ID instruction reads rs2.
- i_id_rd  in  REG_AW  rd address of the ID instruction.
- i_id_rd_wren  in  1  ID instruction writes rd.
- i_ex_pc_sel  in  1  EX resolved a taken branch/jump this cycle.
- i_lsu_stall  in  1  LSU busy; freeze the whole pipeline.
- o_pc_en  out  1  PC register load enable.
- o_if_id_en  out  1  IF/ID register enable.
- o_if_id_flush  out  1  IF/ID register clear (inserts NOP).
- o_id_ex_en  out  1  ID/EX register enable.
- o_id_ex_flush  out  1  ID/EX register clear; top level inverts it onto that register's active-low clear.
- o_ex_mem_en  out  1  EX/MEM register enable.
- o_mem_wb_en  out  1  MEM/WB register enable.
- o_raw_stall  out  1  RAW stall applied this cycle.
- o_stall_cnt  out  CNT_W  cycles spent in RAW stall.
- o_flush_cnt  out  CNT_W  redirect flush events.

Behaviour:
- Scoreboard: three slots, S_EX, S_MEM and S_WB, each holding {wr, rd}. Reset clears every slot to {0, 0}.
- Hit rule: hit_k = S_k.wr and S_k.rd != 0 and ((rs1_used and rs1 == S_k.rd) or (rs2_used and rs2 == S_k.rd)).
  - S_WB is ignored when WB_BYPASS = 1.
  - raw = i_id_vld and (any hit_k).
- Modes are mutually exclusive and evaluated in priority order, highest first. All control outputs are combinational from current inputs and scoreboard state.
- FREEZE (i_lsu_stall = 1):
  - All enables = 0 and both flushes = 0.
  - Scoreboard holds; counters hold; o_raw_stall = 0.
- REDIRECT (i_ex_pc_sel = 1):
  - All enables = 1; o_if_id_flush = 1; o_id_ex_flush = 1.
  - Scoreboard: S_EX <= {0, 0}, S_MEM <= S_EX, S_WB <= S_MEM.
  - o_flush_cnt increments by 1.
  - Redirect wins over a simultaneous RAW hit.
- RAW:
  - o_pc_en = 0, o_if_id_en = 0, o_id_ex_en = 1, o_id_ex_flush = 1 (bubble), o_ex_mem_en = 1, o_mem_wb_en = 1, o_if_id_flush = 0, o_raw_stall = 1.
  - Scoreboard shifts with S_EX <= {0, 0}.
  - o_stall_cnt increments by 1.
- RUN:
  - All enables = 1 and both flushes = 0.
  - S_EX <= {i_id_vld and i_id_rd_wren, i_id_rd}; S_MEM <= S_EX; S_WB <= S_MEM.
- Stall latency with WB_BYPASS = 0, by producer-to-consumer distance: adjacent = 3 stall cycles, distance 2 = 2, distance 3 = 1, distance 4 or more = 0. With WB_BYPASS = 1 each value drops by 1.
- x0 never causes a hazard. A consumer with rs_used = 0 never stalls on that operand.
- Counters saturate at all-ones and never wrap.
- During a cycle with i_reset = 1:
  - Outputs: all enables = 1, o_if_id_flush = 1, o_id_ex_flush = 1, o_raw_stall = 0.
  - State: the scoreboard and both counters clear on that edge.
- Reset mid-stall abandons the stall. The first cycle after reset is in RUN unless inputs dictate otherwise.

Test Plan:
- Reset, then an adjacent dependency: ID writes x5 (wr = 1), next ID reads x5 via rs1 → o_raw_stall = 1 for exactly 3 cycles with o_pc_en = 0 and o_id_ex_flush = 1 in each; cycle 4 is RUN; o_stall_cnt = 3.
- Distance sweep: producer of x7, then 0/1/2/3 independent instructions, then a consumer of x7 → 3/2/1/0 stall cycles. Repeat with WB_BYPASS = 1 → 2/1/0/0.
- x0 and unused operands: producer rd = 0 wr = 1 with consumer rs1 = 0, and producer rd = 9 with consumer rs2 = 9 but rs2_used = 0 → no stall, counters stay 0.
- Redirect plus RAW in the same cycle: raw hit with i_ex_pc_sel = 1 → both flushes = 1, o_pc_en = 1, o_raw_stall = 0; o_flush_cnt goes 0 → 1 and o_stall_cnt is unchanged.
- Freeze mid-stall: during stall cycle 2, hold i_lsu_stall = 1 for 4 cycles → all enables = 0 and the scoreboard holds. After release, exactly 2 more stall cycles follow, and o_stall_cnt = 3.
- Saturation and mid-stall reset:
  - Force o_stall_cnt to all-ones minus 1 and apply 3 stall cycles → the counter stays at all-ones.
  - Assert i_reset during a stall → the next cycle reports o_stall_cnt = 0 and o_raw_stall = 0.
